branch_resolve_unit: RTL and testbench



---
 rtl/branch_resolve_unit_if.sv | 28 ++
 rtl/branch_resolve_unit.sv | 102 ++++++++++
 tb/tb_branch_resolve_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: control-unit <-> branch resolution stage signal bundle
interface branch_resolve_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  start;
    logic [1:0]            branch_ctrl;
    logic                  zero;
    logic                  gt;
    logic [ADDR_WIDTH-1:0] target_addr;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  busy;
    logic                  done;
    logic                  taken;
    logic                  pc_write;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [CNT_WIDTH-1:0]  branch_count;
    logic [CNT_WIDTH-1:0]  taken_count;

    modport master (
        output start, branch_ctrl, zero, gt, target_addr, pc_plus4,
        input  busy, done, taken, pc_write, pc_next, branch_count, taken_count
    );
    modport slave (
        input  start, branch_ctrl, zero, gt, target_addr, pc_plus4,
        output busy, done, taken, pc_write, pc_next, branch_count, taken_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: 3-cycle branch condition resolve with PC write strobe and saturating stats
module branch_resolve_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input logic                 clk,
    input logic                 reset,
    branch_resolve_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_t;

    state_t                state_q, state_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic                  zero_q, zero_d;
    logic                  gt_q, gt_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic [ADDR_WIDTH-1:0] pc4_q, pc4_d;
    logic                  taken_q, taken_d;
    logic [ADDR_WIDTH-1:0] pc_next_q, pc_next_d;
    logic                  done_q, done_d;
    logic                  pc_write_q, pc_write_d;
    logic [CNT_WIDTH-1:0]  branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0]  taken_count_q, taken_count_d;
    logic                  cond;

    // bit 0 of the select inverts the chosen flag
    assign cond = ctrl_q[1] ? (gt_q ^ ctrl_q[0]) : (zero_q ^ ctrl_q[0]);

    always_comb begin
        state_d        = state_q;
        ctrl_d         = ctrl_q;
        zero_d         = zero_q;
        gt_d           = gt_q;
        target_d       = target_q;
        pc4_d          = pc4_q;
        taken_d        = taken_q;
        pc_next_d      = pc_next_q;
        done_d         = 1'b0;
        pc_write_d     = 1'b0;
        branch_count_d = branch_count_q;
        taken_count_d  = taken_count_q;
        case (state_q)
            IDLE: if (bus.start) begin
                ctrl_d   = bus.branch_ctrl;
                zero_d   = bus.zero;
                gt_d     = bus.gt;
                target_d = bus.target_addr;
                pc4_d    = bus.pc_plus4;
                state_d  = EVAL;
            end
            EVAL: begin
                taken_d        = cond;
                pc_next_d      = cond ? target_q : pc4_q;
                branch_count_d = branch_count_q + CNT_WIDTH'(branch_count_q != '1);
                taken_count_d  = taken_count_q + CNT_WIDTH'(cond && taken_count_q != '1);
                done_d         = 1'b1;
                pc_write_d     = cond;
                state_d        = COMMIT;
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            ctrl_q         <= '0;
            zero_q         <= 1'b0;
            gt_q           <= 1'b0;
            target_q       <= '0;
            pc4_q          <= '0;
            taken_q        <= 1'b0;
            pc_next_q      <= '0;
            done_q         <= 1'b0;
            pc_write_q     <= 1'b0;
            branch_count_q <= '0;
            taken_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            ctrl_q         <= ctrl_d;
            zero_q         <= zero_d;
            gt_q           <= gt_d;
            target_q       <= target_d;
            pc4_q          <= pc4_d;
            taken_q        <= taken_d;
            pc_next_q      <= pc_next_d;
            done_q         <= done_d;
            pc_write_q     <= pc_write_d;
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    assign bus.busy         = state_q != IDLE;
    assign bus.done         = done_q;
    assign bus.taken        = taken_q;
    assign bus.pc_write     = pc_write_q;
    assign bus.pc_next      = pc_next_q;
    assign bus.branch_count = branch_count_q;
    assign bus.taken_count  = taken_count_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed scoreboard bench, counters narrowed to 4 bits for saturation
module tb_branch_resolve_unit;
    localparam logic [31:0] TGT = 32'h0040_0100;
    localparam logic [31:0] PC4 = 32'h0040_0004;

    typedef struct packed {
        logic        t;
        logic [31:0] pc;
        logic [3:0]  bc;
        logic [3:0]  tc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   bc_m = 0;
    int   tc_m = 0;
    exp_t q[$];
    exp_t last_e;

    branch_resolve_unit_if #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) bus ();
    branch_resolve_unit #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_cond(input logic [1:0] c, input logic z, input logic g);
        case (c)
            2'b00:   return z;
            2'b01:   return !z;
            2'b10:   return g;
            default: return !g;
        endcase
    endfunction

    task automatic push_exp(input logic [1:0] c, input logic z, input logic g,
                            input logic [31:0] tgt, input logic [31:0] pc4);
        exp_t e;
        e.t  = exp_cond(c, z, g);
        e.pc = e.t ? tgt : pc4;
        bc_m = (bc_m == 15) ? 15 : bc_m + 1;
        if (e.t) tc_m = (tc_m == 15) ? 15 : tc_m + 1;
        e.bc = 4'(bc_m);
        e.tc = 4'(tc_m);
        q.push_back(e);
    endtask

    task automatic check_commit();
        if (q.size() == 0) begin
            chk("sb_empty", 32'(q.size()), 1);
            return;
        end
        last_e = q.pop_front();
        chk("done", 32'(bus.done), 1);
        chk("taken", 32'(bus.taken), 32'(last_e.t));
        chk("pc_write", 32'(bus.pc_write), 32'(last_e.t));
        chk("pc_next", bus.pc_next, last_e.pc);
        chk("branch_count", 32'(bus.branch_count), 32'(last_e.bc));
        chk("taken_count", 32'(bus.taken_count), 32'(last_e.tc));
    endtask

    // called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic issue(input logic [1:0] c, input logic z, input logic g,
                         input logic [31:0] tgt, input logic [31:0] pc4);
        int n;
        bus.start = 1'b1;
        bus.branch_ctrl = c;
        bus.zero = z;
        bus.gt = g;
        bus.target_addr = tgt;
        bus.pc_plus4 = pc4;
        push_exp(c, z, g, tgt, pc4);
        @(negedge clk);
        bus.start = 1'b0;
        bus.branch_ctrl = ~c;
        bus.zero = ~z;
        bus.gt = ~g;
        bus.target_addr = $urandom;
        bus.pc_plus4 = $urandom;
        chk("busy_eval", 32'(bus.busy), 1);
        chk("done_early", 32'(bus.done), 0);
        n = 0;
        while (bus.done !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            chk("done_timeout", 32'(bus.done), 1);
            void'(q.pop_front());
        end else begin
            chk("latency", 32'(n), 1);
            check_commit();
        end
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 0);
        chk("pc_write_pulse", 32'(bus.pc_write), 0);
        chk("busy_idle", 32'(bus.busy), 0);
        chk("taken_hold", 32'(bus.taken), 32'(last_e.t));
        chk("pc_next_hold", bus.pc_next, last_e.pc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bc_m = 0;
        tc_m = 0;
        q.delete();
    endtask

    initial begin
        int last;
        int pulses;
        reset = 1'b1;
        bus.start = 1'b1;
        bus.branch_ctrl = 2'b01;
        bus.zero = 1'b0;
        bus.gt = 1'b0;
        bus.target_addr = TGT;
        bus.pc_plus4 = PC4;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_taken", 32'(bus.taken), 0);
        chk("rst_pc_write", 32'(bus.pc_write), 0);
        chk("rst_pc_next", bus.pc_next, 0);
        chk("rst_branch_count", 32'(bus.branch_count), 0);
        chk("rst_taken_count", 32'(bus.taken_count), 0);
        reset = 1'b0;
        issue(2'b01, 1'b0, 1'b0, TGT, PC4);

        do_reset();
        bus.start = 1'b1;
        bus.branch_ctrl = 2'b00;
        bus.zero = 1'b1;
        bus.gt = 1'b0;
        bus.target_addr = TGT;
        bus.pc_plus4 = PC4;
        repeat (3) push_exp(2'b00, 1'b1, 1'b0, TGT, PC4);
        last = 0;
        pulses = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                pulses++;
                if (last != 0) chk("done_spacing", 32'(i - last), 3);
                last = i;
                check_commit();
            end
        end
        bus.start = 1'b0;
        chk("busy_pulses", 32'(pulses), 3);
        chk("busy_branch_count", 32'(bus.branch_count), 3);

        @(negedge clk);
        bus.start = 1'b1;
        bus.branch_ctrl = 2'b00;
        bus.zero = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bc_m = 0;
        tc_m = 0;
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_done", 32'(bus.done), 0);
        chk("midrst_pc_write", 32'(bus.pc_write), 0);
        chk("midrst_branch_count", 32'(bus.branch_count), 0);
        chk("midrst_taken_count", 32'(bus.taken_count), 0);
        @(negedge clk);
        chk("midrst_done_late", 32'(bus.done), 0);
        chk("midrst_pc_write_late", 32'(bus.pc_write), 0);

        for (int c = 0; c < 4; c++)
            for (int f = 0; f < 4; f++)
                issue(2'(c), f[1], f[0], TGT, PC4);
        issue(2'b00, 1'b1, 1'b0, TGT, PC4);

        repeat (17) issue(2'b10, 1'b0, 1'b1, TGT, PC4);
        chk("sat_branch_count", 32'(bus.branch_count), 15);
        chk("sat_taken_count", 32'(bus.taken_count), 15);
        issue(2'b00, 1'b0, 1'b0, TGT, PC4);
        chk("sat_nt_branch_count", 32'(bus.branch_count), 15);
        chk("sat_nt_taken_count", 32'(bus.taken_count), 15);
        chk("sat_nt_pc_next", bus.pc_next, PC4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
